// File: rtl/fork_cond_sched_pkg.sv
// Shared types and constants for the conditional-fork token scheduler.
package fork_cond_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SETUP    = 2'd1,
      ST_WAIT_ACK = 2'd2
   } state_e;

   // Bit positions inside a routing mask.
   localparam int MASK_CH1 = 0;
   localparam int MASK_CH2 = 1;

endpackage : fork_cond_sched_pkg

// File: rtl/fork_cond_sched_2ph_if.sv
// Token input handshake plus the 2-phase fork link and status outputs.
interface fork_cond_sched_2ph_if #(
   parameter int CNT_WIDTH = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [1:0]           in_mask;
   logic                 r;
   logic                 a;
   logic                 cond1;
   logic                 cond2;
   logic                 busy;
   logic [CNT_WIDTH-1:0] tok_cnt;
   logic                 err;

   // Producer / fork side: drives tokens and the acknowledge.
   modport master (
      output in_valid, in_mask, a,
      input  in_ready, r, cond1, cond2, busy, tok_cnt, err
   );

   // Scheduler side.
   modport slave (
      input  in_valid, in_mask, a,
      output in_ready, r, cond1, cond2, busy, tok_cnt, err
   );
endinterface : fork_cond_sched_2ph_if

// File: rtl/sync_ff.sv
// Multi-flop synchronizer for a single asynchronous level.
module sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // Shift the raw input one stage deeper every clock.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   // Synchronizer chain, cleared by reset.
   // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would collapse the chain.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) sync_q <= '0;
      else       sync_q <= sync_d;
   end

   assign q = sync_q[STAGES-1];

endmodule : sync_ff

// File: rtl/fork_cond_sched_2ph.sv
// Routing-mask FIFO feeding a 2-phase request/acknowledge scheduler for a conditional fork.
module fork_cond_sched_2ph
   import fork_cond_sched_pkg::*;
#(
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 8
) (
   input logic                  clk,
   input logic                  rstn,
   fork_cond_sched_2ph_if.slave bus
);

   localparam int AW = $clog2(DEPTH);

   localparam logic [AW:0]          PTR_INC = {{AW{1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_INC = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   // FIFO storage and pointers (extra MSB tells full from empty).
   logic [1:0]     mem_q [DEPTH];
   logic [AW:0]    wr_ptr_q, wr_ptr_d;
   logic [AW:0]    rd_ptr_q, rd_ptr_d;
   logic           full, empty, push, pop;
   logic [1:0]     head;

   // Scheduler state.
   state_e               state_q, state_d;
   logic                 r_q, r_d;
   logic                 cond1_q, cond1_d;
   logic                 cond2_q, cond2_d;
   logic                 busy_q, busy_d;
   logic                 err_q, err_d;
   logic [CNT_WIDTH-1:0] tok_cnt_q, tok_cnt_d;
   logic                 a_s;

   sync_ff #(.STAGES(SYNC_STAGES)) u_sync_a (
      .clk  (clk),
      .rstn (rstn),
      .d    (bus.a),
      .q    (a_s)
   );

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   // Push depends on full only, so a same-cycle pop never makes room for a push.
   assign push  = bus.in_valid && !full;
   assign pop   = (state_q == ST_IDLE) && !empty;
   assign head  = mem_q[rd_ptr_q[AW-1:0]];

   // Mask storage write.
   // NOTE: the data array has no reset; pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.in_mask;
   end

   // Pointer advance on push and pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + PTR_INC;
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_INC;
   end

   // Next state: load conditions, issue the request edge, wait for the matching acknowledge.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
      state_d   = state_q;
      r_d       = r_q;
      cond1_d   = cond1_q;
      cond2_d   = cond2_q;
      tok_cnt_d = tok_cnt_q;
      err_d     = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (!empty) begin
               cond1_d = head[MASK_CH1];
               cond2_d = head[MASK_CH2];
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            r_d     = ~r_q;
            state_d = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            if (a_s == r_q) begin
               tok_cnt_d = tok_cnt_q + CNT_INC;
               state_d   = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Outside WAIT_ACK the fork has nothing outstanding, so its acknowledge must match r.
      if ((state_q == ST_IDLE || state_q == ST_SETUP) && (a_s != r_q)) err_d = 1'b1;

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         state_q   <= ST_IDLE;
         r_q       <= 1'b0;
         cond1_q   <= 1'b0;
         cond2_q   <= 1'b0;
         busy_q    <= 1'b0;
         err_q     <= 1'b0;
         tok_cnt_q <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         state_q   <= state_d;
         r_q       <= r_d;
         cond1_q   <= cond1_d;
         cond2_q   <= cond2_d;
         busy_q    <= busy_d;
         err_q     <= err_d;
         tok_cnt_q <= tok_cnt_d;
      end
   end

   assign bus.in_ready = !full;
   assign bus.r        = r_q;
   assign bus.cond1    = cond1_q;
   assign bus.cond2    = cond2_q;
   assign bus.busy     = busy_q;
   assign bus.err      = err_q;
   assign bus.tok_cnt  = tok_cnt_q;

endmodule : fork_cond_sched_2ph

// File: tb/tb_fork_cond_sched_2ph.sv
// Randomised scoreboard bench for fork_cond_sched_2ph with a behavioural 2-phase fork.
module tb_fork_cond_sched_2ph;

   localparam int DEPTH       = 4;
   localparam int SYNC_STAGES = 2;
   localparam int CNT_WIDTH   = 8;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   fork_cond_sched_2ph_if #(.CNT_WIDTH(CNT_WIDTH)) bus ();

   fork_cond_sched_2ph #(
      .DEPTH       (DEPTH),
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_WIDTH   (CNT_WIDTH)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus.slave)
   );

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   int         issued;          // tokens accepted since the last reset
   int         toggles = 0;     // r edges seen over the whole run
   int         last_tog = 0;
   int         gap = 0;
   logic [1:0] exp_q [$];       // masks owed to the fork, oldest first
   logic       prev_r;
   logic       prev_busy;
   logic [1:0] prev_cond;
   bit         fork_auto;       // fork answers requests on its own
   bit         rand_delay;      // new random answer delay per request
   int         a_delay;
   int         pend;

   // One clock: log the handshake, score any r edge, check cond stability, then let the fork respond.
   task automatic cycle();
      logic       rdy;
      logic [1:0] e;
      rdy = bus.in_ready;
      @(posedge clk);
      if (bus.in_valid && rdy) begin
         exp_q.push_back(bus.in_mask);
         issued++;
      end
      #1;
      cyc++;
      if (bus.r !== prev_r) begin
         toggles++;
         gap      = cyc - last_tog;
         last_tog = cyc;
         prev_r   = bus.r;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL r_edge: r toggled to %0b with no token owed", bus.r);
         end else begin
            e = exp_q.pop_front();
            if ({bus.cond2, bus.cond1} !== e) begin
               bad++;
               $display("FAIL cond_at_r: got {cond2,cond1}=%b expected %b", {bus.cond2, bus.cond1}, e);
            end
         end
         if (rand_delay) a_delay = $urandom_range(0, 20);
      end
      if (prev_busy && bus.busy) begin
         total++;
         if ({bus.cond2, bus.cond1} !== prev_cond) begin
            bad++;
            $display("FAIL cond_stable: got %b expected %b while busy", {bus.cond2, bus.cond1}, prev_cond);
         end
      end
      prev_busy = bus.busy;
      prev_cond = {bus.cond2, bus.cond1};
      if (fork_auto && bus.a !== bus.r) begin
         if (pend >= a_delay) begin
            bus.a = bus.r;
            pend  = 0;
         end else begin
            pend++;
         end
      end
   endtask

   // Run until every owed token has been requested and acknowledged.
   task automatic drain(input string name);
      int n;
      n = 0;
      bus.in_valid = 1'b0;
      while ((exp_q.size() != 0 || bus.busy) && n < 2000) begin
         cycle();
         n++;
      end
      total++;
      if (exp_q.size() != 0 || bus.busy) begin
         bad++;
         $display("FAIL %s_drain: %0d tokens still owed, busy=%0b after %0d cycles", name, exp_q.size(), bus.busy, n);
      end
   endtask

   // Assert reset, reset the fork model, release reset away from the clock edge.
   task automatic do_reset();
      rstn         = 1'b0;
      bus.a        = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_mask  = 2'b00;
      pend         = 0;
      issued       = 0;
      prev_r       = 1'b0;
      prev_busy    = 1'b0;
      prev_cond    = 2'b00;
      exp_q.delete();
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if ({bus.r, bus.cond1, bus.cond2, bus.busy, bus.err} !== 5'b0) begin
         bad++;
         $display("FAIL reset_outputs: {r,cond1,cond2,busy,err}=%b expected 00000",
                  {bus.r, bus.cond1, bus.cond2, bus.busy, bus.err});
      end
      total++;
      if (bus.tok_cnt !== 8'd0) begin
         bad++;
         $display("FAIL reset_tok_cnt: got %0d expected 0", bus.tok_cnt);
      end
      total++;
      if (bus.in_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
      end
   endtask

   // One 01 token into an idle, empty scheduler: r rises two edges after the push.
   task automatic test_single();
      fork_auto = 1'b1;
      a_delay   = 3;
      bus.in_valid = 1'b1;
      bus.in_mask  = 2'b01;
      cycle();                         // edge N: push
      bus.in_valid = 1'b0;
      total++;
      if ({bus.r, bus.busy} !== 2'b00) begin
         bad++;
         $display("FAIL single_edge_n: {r,busy}=%b expected 00", {bus.r, bus.busy});
      end
      cycle();                         // edge N+1: conditions loaded
      total++;
      if ({bus.r, bus.busy, bus.cond2, bus.cond1} !== 4'b0101) begin
         bad++;
         $display("FAIL single_edge_n1: {r,busy,cond2,cond1}=%b expected 0101",
                  {bus.r, bus.busy, bus.cond2, bus.cond1});
      end
      cycle();                         // edge N+2: request edge
      total++;
      if (bus.r !== 1'b1) begin
         bad++;
         $display("FAIL single_latency: r=%b at edge N+2 expected 1", bus.r);
      end
      drain("single");
      total++;
      if ({bus.tok_cnt, bus.busy, bus.err} !== {8'd1, 2'b00}) begin
         bad++;
         $display("FAIL single_done: tok_cnt=%0d busy=%b err=%b expected 1 0 0", bus.tok_cnt, bus.busy, bus.err);
      end
   endtask

   // Hold the acknowledge: a first token parks in WAIT_ACK, then 11,10,01,00 fill the FIFO.
   task automatic test_fill();
      logic [1:0] seq [4];
      int         t0, n;
      seq = '{2'b11, 2'b10, 2'b01, 2'b00};
      fork_auto = 1'b0;
      a_delay   = 0;
      t0 = toggles;
      bus.in_valid = 1'b1;
      bus.in_mask  = 2'b10;
      cycle();
      bus.in_valid = 1'b0;
      repeat (3) cycle();
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_mask  = seq[i];
         cycle();
      end
      total++;
      if (bus.in_ready !== 1'b0) begin
         bad++;
         $display("FAIL fill_in_ready: got %b expected 0 with FIFO full", bus.in_ready);
      end
      total++;
      if (toggles - t0 != 1) begin
         bad++;
         $display("FAIL fill_held: %0d r edges while a held, expected 1", toggles - t0);
      end
      // Keep offering 11 while the fork drains; only handshakes seen with in_ready high are owed.
      bus.in_mask = 2'b11;
      fork_auto   = 1'b1;
      n = 0;
      while (issued < 7 && n < 200) begin
         cycle();
         n++;
      end
      drain("fill");
      total++;
      if (bus.tok_cnt !== 8'(issued % 256)) begin
         bad++;
         $display("FAIL fill_tok_cnt: got %0d expected %0d", bus.tok_cnt, issued % 256);
      end
   endtask

   // Immediate acknowledge with a full FIFO: r edges are SYNC_STAGES+3 apart.
   task automatic test_back_to_back();
      int base, t0, n, seen;
      fork_auto = 1'b1;
      a_delay   = 0;
      base = issued;
      t0   = toggles;
      seen = toggles;
      n    = 0;
      while (toggles - t0 < 6 && n < 200) begin
         bus.in_valid = (issued - base < 6);
         bus.in_mask  = 2'($urandom_range(0, 3));
         cycle();
         n++;
         if (toggles != seen) begin
            seen = toggles;
            if (toggles - t0 > 1) begin
               total++;
               if (gap != SYNC_STAGES + 3) begin
                  bad++;
                  $display("FAIL b2b_spacing: r edges %0d cycles apart expected %0d", gap, SYNC_STAGES + 3);
               end
            end
         end
      end
      drain("b2b");
      total++;
      if (toggles - t0 != 6) begin
         bad++;
         $display("FAIL b2b_count: %0d r edges expected 6", toggles - t0);
      end
   endtask

   // An acknowledge edge with nothing outstanding is a sticky error.
   task automatic test_err();
      fork_auto = 1'b0;
      bus.a = ~bus.a;
      repeat (4) cycle();
      total++;
      if (bus.err !== 1'b1) begin
         bad++;
         $display("FAIL err_set: got %b expected 1", bus.err);
      end
      bus.a = ~bus.a;
      repeat (4) cycle();
      total++;
      if (bus.err !== 1'b1) begin
         bad++;
         $display("FAIL err_sticky: got %b expected 1", bus.err);
      end
      test_reset();
   endtask

   // 255 completions take the counter to its maximum; one more wraps it to zero.
   task automatic test_wrap();
      int n;
      fork_auto = 1'b1;
      a_delay   = 0;
      n = 0;
      while (issued < 255 && n < 5000) begin
         bus.in_valid = 1'b1;
         bus.in_mask  = 2'($urandom_range(0, 3));
         cycle();
         bus.in_valid = 1'b0;
         n++;
      end
      drain("wrap_pre");
      total++;
      if (bus.tok_cnt !== 8'd255) begin
         bad++;
         $display("FAIL wrap_preset: tok_cnt=%0d expected 255", bus.tok_cnt);
      end
      bus.in_valid = 1'b1;
      bus.in_mask  = 2'b00;
      cycle();
      drain("wrap");
      total++;
      if ({bus.tok_cnt, bus.err} !== {8'd0, 1'b0}) begin
         bad++;
         $display("FAIL wrap: tok_cnt=%0d err=%b expected 0 0", bus.tok_cnt, bus.err);
      end
   endtask

   // Reset while waiting for an acknowledge abandons the token; the next one runs normally.
   task automatic test_reset_mid();
      int n;
      fork_auto = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_mask  = 2'b01;
      cycle();
      bus.in_valid = 1'b0;
      n = 0;
      while (bus.r === prev_r && n < 2) begin
         cycle();
         n++;
      end
      cycle();
      total++;
      if ({bus.busy, bus.r} !== 2'b11) begin
         bad++;
         $display("FAIL mid_in_flight: {busy,r}=%b expected 11", {bus.busy, bus.r});
      end
      rstn  = 1'b0;
      bus.a = 1'b0;
      #1;
      total++;
      if ({bus.r, bus.cond1, bus.cond2, bus.busy, bus.err, bus.tok_cnt, bus.in_ready} !== {5'b0, 8'd0, 1'b1}) begin
         bad++;
         $display("FAIL mid_reset: {r,cond1,cond2,busy,err}=%b tok_cnt=%0d in_ready=%b expected 00000 0 1",
                  {bus.r, bus.cond1, bus.cond2, bus.busy, bus.err}, bus.tok_cnt, bus.in_ready);
      end
      do_reset();
      fork_auto = 1'b1;
      a_delay   = 2;
      bus.in_valid = 1'b1;
      bus.in_mask  = 2'b10;
      cycle();
      drain("mid_after");
      total++;
      if ({bus.tok_cnt, bus.err} !== {8'd1, 1'b0}) begin
         bad++;
         $display("FAIL mid_after: tok_cnt=%0d err=%b expected 1 0", bus.tok_cnt, bus.err);
      end
   endtask

   // 1000 random tokens, random offer pattern, random acknowledge delay 0..20.
   task automatic test_random();
      int base, t0, n;
      test_reset();
      fork_auto  = 1'b1;
      rand_delay = 1'b1;
      a_delay    = $urandom_range(0, 20);
      base = issued;
      t0   = toggles;
      n    = 0;
      while (issued - base < 1000 && n < 60000) begin
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.in_mask  = 2'($urandom_range(0, 3));
         cycle();
         n++;
      end
      drain("random");
      rand_delay = 1'b0;
      total++;
      if (toggles - t0 != 1000) begin
         bad++;
         $display("FAIL random_count: %0d r edges expected 1000", toggles - t0);
      end
      total++;
      if ({bus.tok_cnt, bus.err} !== {8'(1000 % 256), 1'b0}) begin
         bad++;
         $display("FAIL random_tok_cnt: tok_cnt=%0d err=%b expected %0d 0", bus.tok_cnt, bus.err, 1000 % 256);
      end
   endtask

   initial begin
      fork_auto    = 1'b0;
      rand_delay   = 1'b0;
      a_delay      = 0;
      bus.in_valid = 1'b0;
      bus.in_mask  = 2'b00;
      bus.a        = 1'b0;
      test_reset();
      test_single();
      test_fill();
      test_back_to_back();
      test_err();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_fork_cond_sched_2ph
